// File: rtl/day_of_year_counter.sv
// Day-of-year counter: holds a day value in 1..DAY_MAX and advances it from a
// prescaled tick while running, or from a debounced step key while paused. A
// second debounced key toggles between paused and running.
module day_of_year_counter #(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DAY_MAX         = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_step_n,
    input  logic       key_run_n,
    input  logic       sw_down,
    output logic [7:0] day_tmp,
    output logic       day_change,
    output logic       running
);

    localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PresW-1:0] TickLast = PresW'(TICK_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       DayMax   = 8'(DAY_MAX);

    typedef enum logic [0:0] {StPaused, StRunning} state_e;

    // Bit order in the synchronizer vectors: {sw_down, key_run_n, key_step_n}
    logic [2:0] sync1_q, sync2_q;

    logic            step_stable_q, step_stable_d;
    logic            run_stable_q, run_stable_d;
    logic [DebW-1:0] step_cnt_q, step_cnt_d;
    logic [DebW-1:0] run_cnt_q, run_cnt_d;
    logic            step_ev_q, run_ev_q;

    state_e           state_q, state_d;
    logic [PresW-1:0] pres_q, pres_d;
    logic [7:0]       day_q, day_d;
    logic             day_change_q, day_change_d;
    logic             advance;

    // One step in the selected direction; 0 is treated like 1 so it never escapes.
    function automatic logic [7:0] next_day(input logic [7:0] d, input logic down);
        if (down) begin
            return (d <= 8'd1) ? DayMax : d - 8'd1;
        end
        return (d >= DayMax) ? 8'd1 : d + 8'd1;
    endfunction

    // Two-flop synchronizers for both keys and the direction switch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {sw_down, key_run_n, key_step_n};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing cycles
    always_comb begin
        step_stable_d = step_stable_q;
        step_cnt_d    = '0;
        if (sync2_q[0] != step_stable_q) begin
            if (step_cnt_q == DebLast) begin
                step_stable_d = sync2_q[0];
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end

        run_stable_d = run_stable_q;
        run_cnt_d    = '0;
        if (sync2_q[1] != run_stable_q) begin
            if (run_cnt_q == DebLast) begin
                run_stable_d = sync2_q[1];
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and registered press pulses (falling edge of the stable level only)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_stable_q <= 1'b1;
            run_stable_q  <= 1'b1;
            step_cnt_q    <= '0;
            run_cnt_q     <= '0;
            step_ev_q     <= 1'b0;
            run_ev_q      <= 1'b0;
        end else begin
            step_stable_q <= step_stable_d;
            run_stable_q  <= run_stable_d;
            step_cnt_q    <= step_cnt_d;
            run_cnt_q     <= run_cnt_d;
            step_ev_q     <= step_stable_q & ~step_stable_d;
            run_ev_q      <= run_stable_q & ~run_stable_d;
        end
    end

    // Mode FSM, prescaler and day next-state; a run event always wins over step/tick
    always_comb begin
        state_d      = state_q;
        pres_d       = '0;
        advance      = 1'b0;
        unique case (state_q)
            StPaused: begin
                if (run_ev_q) begin
                    state_d = StRunning;
                end else if (step_ev_q) begin
                    advance = 1'b1;
                end
            end
            StRunning: begin
                if (run_ev_q) begin
                    state_d = StPaused;
                end else if (pres_q == TickLast) begin
                    advance = 1'b1;
                end else begin
                    pres_d = pres_q + 1'b1;
                end
            end
            default: state_d = StPaused;
        endcase

        day_d        = advance ? next_day(day_q, sync2_q[2]) : day_q;
        day_change_d = advance;
    end

    // Mode, prescaler and day registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPaused;
            pres_q       <= '0;
            day_q        <= 8'd1;
            day_change_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pres_q       <= pres_d;
            day_q        <= day_d;
            day_change_q <= day_change_d;
        end
    end

    assign day_tmp    = day_q;
    assign day_change = day_change_q;
    assign running    = (state_q == StRunning);

endmodule

// File: tb/tb_day_of_year_counter.sv
// Bench for day_of_year_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3, DAY_MAX=99.
// Expected day values are queued when a key press is driven and popped by a
// monitor whenever day_change is seen.
module tb_day_of_year_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_step_n;
    logic       key_run_n;
    logic       sw_down;
    logic [7:0] day_tmp;
    logic       day_change;
    logic       running;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int chg_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       sw;
        logic [7:0] exp_day;
    } vec_t;
    vec_t vecs[9];

    day_of_year_counter #(
        .TICK_DIV(4),
        .DEBOUNCE_CYCLES(3),
        .DAY_MAX(99)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_step_n(key_step_n),
        .key_run_n(key_run_n),
        .sw_down(sw_down),
        .day_tmp(day_tmp),
        .day_change(day_change),
        .running(running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every day_change pulse must match the next queued value
    always @(negedge clk) begin
        if (reset_n && day_change) begin
            chg_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change: got day %0d expected no change (cycle %0d)",
                         day_tmp, cyc);
            end else begin
                check("sb_day", int'(day_tmp), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic press_step(input logic sw, input int hold);
        @(negedge clk);
        sw_down    = sw;
        key_step_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_step_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic press_run();
        @(negedge clk);
        key_run_n = 1'b0;
        repeat (6) @(negedge clk);
        key_run_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int base;
        int r;
        int nchg;
        int e;
        bit seen;

        vecs[0] = '{sw: 1'b1, exp_day: 8'd1};
        vecs[1] = '{sw: 1'b1, exp_day: 8'd99};
        vecs[2] = '{sw: 1'b0, exp_day: 8'd1};
        vecs[3] = '{sw: 1'b0, exp_day: 8'd2};
        vecs[4] = '{sw: 1'b1, exp_day: 8'd1};
        vecs[5] = '{sw: 1'b1, exp_day: 8'd99};
        vecs[6] = '{sw: 1'b1, exp_day: 8'd98};
        vecs[7] = '{sw: 1'b0, exp_day: 8'd99};
        vecs[8] = '{sw: 1'b0, exp_day: 8'd1};

        reset_n    = 1'b0;
        key_step_n = 1'b1;
        key_run_n  = 1'b1;
        sw_down    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_day", int'(day_tmp), 1);
        check("reset_change", int'(day_change), 0);
        check("reset_running", int'(running), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Long press: exactly one advance, nothing on release
        exp_q.push_back(8'd2);
        base = chg_cnt;
        press_step(1'b0, 10);
        repeat (10) @(negedge clk);
        check("long_press_pulses", chg_cnt - base, 1);
        check("long_press_day", int'(day_tmp), 2);

        // Table of manual steps, including both wrap directions
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_day);
            press_step(vecs[i].sw, 6);
            check($sformatf("vec%0d_day", i), int'(day_tmp), int'(vecs[i].exp_day));
        end

        // Bounce shorter than the debounce window: no event
        base = chg_cnt;
        @(negedge clk);
        key_step_n = 1'b0;
        repeat (2) @(negedge clk);
        key_step_n = 1'b1;
        @(negedge clk);
        key_step_n = 1'b0;
        repeat (2) @(negedge clk);
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_pulses", chg_cnt - base, 0);
        check("bounce_day", int'(day_tmp), 1);

        // Bring the day up to 5
        for (int k = 2; k <= 5; k++) begin
            exp_q.push_back(8'(k));
            press_step(1'b0, 6);
        end
        check("pre_run_day", int'(day_tmp), 5);

        // Run: advances every 4 cycles, the first 4 cycles after the run event;
        // a step press in the middle must be ignored
        exp_q.push_back(8'd6);
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd8);
        seen = 1'b0;
        r    = 0;
        nchg = 0;
        for (int i = 0; i < 80 && nchg < 3; i++) begin
            @(negedge clk);
            key_run_n  = (i < 6) ? 1'b0 : 1'b1;
            key_step_n = (i >= 12 && i < 18) ? 1'b0 : 1'b1;
            if (running && !seen) begin
                seen = 1'b1;
                r    = cyc;
            end
            if (day_change) begin
                nchg++;
                check($sformatf("tick%0d_spacing", nchg), cyc - r, 4 * nchg);
            end
        end
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        check("run_ticks_seen", nchg, 3);
        check("running_high", int'(running), 1);

        // Run event landing in the tick cycle: toggle only, no advance
        e = cyc;
        repeat (2) @(negedge clk);
        key_run_n = 1'b0;
        exp_q.push_back(8'd9);
        repeat (2) @(negedge clk);
        check("pre_stop_tick", int'(day_change), 1);
        repeat (3) @(negedge clk);
        check("stop_still_running", int'(running), 1);
        @(negedge clk);
        check("stop_cycle_offset", cyc - e, 8);
        check("stop_running", int'(running), 0);
        check("stop_no_change", int'(day_change), 0);
        repeat (2) @(negedge clk);
        key_run_n = 1'b1;
        base = chg_cnt;
        repeat (20) @(negedge clk);
        check("frozen_pulses", chg_cnt - base, 0);
        check("frozen_day", int'(day_tmp), 9);

        // Run up to day 40 and reset asynchronously between edges
        for (int k = 10; k <= 40; k++) exp_q.push_back(8'(k));
        press_run();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (day_tmp == 8'd40) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_40", int'(seen), 1);
        check("running_at_40", int'(running), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_day", int'(day_tmp), 1);
        check("async_reset_running", int'(running), 0);
        check("async_reset_change", int'(day_change), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = chg_cnt;
        repeat (30) @(negedge clk);
        check("post_reset_pulses", chg_cnt - base, 0);
        check("post_reset_day", int'(day_tmp), 1);
        check("post_reset_running", int'(running), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/day_of_year_counter.md
Name: day_of_year_counter

Overview:
- Upstream stage that generates the 8-bit day-of-year value (day_tmp) consumed by the month-decode/display stage.
- Holds a day count in 1..DAY_MAX.
- Advances the count automatically from a prescaled tick, or manually from a debounced pushbutton.
- A second pushbutton toggles between paused and running.
- A switch selects count direction.
- Targets the board's 50 MHz clock and active-low KEY inputs.

Parameters:
- TICK_DIV, 50000000, clock cycles per automatic advance in RUNNING; must be >= 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a key level change; must be >= 1.
- DAY_MAX, 99, highest day value before wrap; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- key_step_n  input  1  active-low pushbutton, manual single advance (asynchronous to clk)
- key_run_n  input  1  active-low pushbutton, toggles PAUSED/RUNNING (asynchronous to clk)
- sw_down  input  1  0 = count up, 1 = count down (slide switch, synchronized internally)
- day_tmp  output  8  current day, binary, always in 1..DAY_MAX
- day_change  output  1  one-cycle pulse in the cycle day_tmp takes a new value
- running  output  1  1 while in RUNNING state

Behaviour:
- Reset (reset_n low, asynchronous):
  - day_tmp = 1, day_change = 0, state = PAUSED, running = 0.
  - Prescaler = 0.
  - Both debounce counters = 0.
  - Both stable key levels = 1 (released).
  - Synchronizer flops = 1.
  - Reset mid-operation abandons any pending tick or debounce.
- Input conditioning:
  - Each key and sw_down passes through a 2-flop synchronizer.
  - Per key, debounce:
    - If the synchronized level differs from the stable level, the counter increments; otherwise it clears.
    - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the new value and the counter clears.
  - Press event = stable level 1->0 transition, registered as a 1-cycle pulse. Release generates nothing.
  - Bounce shorter than DEBOUNCE_CYCLES produces no event.
- State machine, 2 states:
  - PAUSED:
    - Prescaler held at 0.
    - Step event advances day by one in the selected direction.
    - Run event -> RUNNING.
  - RUNNING:
    - Prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler == TICK_DIV-1).
    - Tick advances day by one.
    - Step events are ignored.
    - Run event -> PAUSED; prescaler clears; a tick in that same cycle is discarded.
  - Entering RUNNING clears the prescaler, so the first advance occurs exactly TICK_DIV cycles after the run event cycle.
- Advance arithmetic, 8-bit unsigned, direction sampled from synchronized sw_down in the advance cycle:
  - Up: DAY_MAX -> 1, else +1.
  - Down: 1 -> DAY_MAX, else -1.
  - Value 0 is never output.
- Latency:
  - day_tmp updates on the clock edge following the event/tick cycle.
  - day_change is high for exactly the cycle in which the new value is first visible.
- Simultaneous events:
  - Run and step events in the same cycle in PAUSED: toggle only, no advance.
  - Both keys are debounced independently.
- Direction change mid-run takes effect at the next tick; no extra advance.
- Holding a key produces exactly one event until released and re-pressed.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, DAY_MAX=99):
1. Reset, key_step_n low for 10 cycles then high, sw_down=0 -> exactly one day_change pulse; day_tmp 1 -> 2; no change on release.
2. From day_tmp=99, PAUSED, sw_down=0, one step press -> day_tmp=1. Then sw_down=1, one step press -> day_tmp=99.
3. key_step_n bounces (low 2 cycles, high 1, low 2, high) -> no event; day_tmp unchanged, day_change never asserts.
4. Run press from day 5 -> running=1; day_tmp=6, 7, 8 at 4-cycle intervals, the first 4 cycles after the run event. A step press during RUNNING changes nothing extra.
5. Run press coinciding with the tick cycle while RUNNING -> running=0, no advance that cycle, day_tmp frozen thereafter.
6. Assert reset_n low asynchronously mid-RUNNING at day 40 -> day_tmp=1, running=0, day_change=0 immediately (before next clk edge). After release, no advance without a key press.
